riscv_irq_ctrl: RTL and testbench
=================================

// Module: riscv_irq_ctrl
// PURPOSE
//  Parametrised platform interrupt controller for the pipelined RISC-V core; replaces the single raw e_intr pin.
//  Latches NUM_SRC sources, each level- or edge-triggered, applies per-source enable/priority and a global threshold.
//  Drives one machine external interrupt line (e_intr_o) into the core's CSR unit.
//  Software claims and completes interrupts over a word-addressed load/store port beside data memory.
// PARAMETERS
//  NUM_SRC  8   number of interrupt sources (1..31); source IDs are 1..NUM_SRC, ID 0 = none
//  PRIO_W   3   priority width; priority 0 = never interrupts
//  ADDRW    12  byte-offset width of the register port
//  DW       32  data width of the register port
// PORTS
//  clk_i      in   1        core clock
//  rst_ni     in   1        asynchronous, active-low reset
//  src_i      in   NUM_SRC  raw interrupt requests; bit i = source ID i+1
//  addr_i     in   ADDRW    byte offset, word aligned (addr_i[1:0] ignored)
//  we_i       in   1        register write strobe
//  wdata_i    in   DW       write data
//  re_i       in   1        register read strobe (CLAIM read has side effects)
//  rdata_o    out  DW       read data, combinational from addr_i; 0 for unmapped offsets
//  e_intr_o   out  1        registered interrupt request to core
// BEHAVIOUR
//  Register map (word offsets):
//   0x00 ENABLE RW; 0x04 MODE RW (1 = edge, 0 = level); 0x08 THRESHOLD RW [PRIO_W-1:0]
//   0x0C CLAIM/COMPLETE; 0x10 PENDING RO; 0x20+4*i PRIORITY[i] RW [PRIO_W-1:0]
//  Reset values:
//   - ENABLE, MODE, THRESHOLD, PRIORITY, pending, in_service, edge history, e_intr_o: all 0.
//   - Reset asserted mid-operation clears everything immediately (asynchronous); no claim survives it.
//  Pending:
//   - Edge mode: set on a 0->1 transition vs the previous sample; reset history = 0.
//   - Level mode: set whenever the sample is 1.
//   - Cleared only by a claim.
//   - Disabling a source masks it but does not clear its pending bit.
//  Eligible source:
//   - pending & enabled & !in_service & PRIORITY > THRESHOLD.
//   - Best = highest priority; ties go to the lowest ID.
//  e_intr_o = registered (any eligible).
//  Latency: src_i rises before posedge k -> pending set at k -> e_intr_o high after k+1.
//  Claim:
//   - re_i at 0x0C returns best ID (0 if none).
//   - At that clock edge: clear that pending bit and set in_service.
//   - e_intr_o re-evaluates the following cycle.
//  Complete:
//   - we_i at 0x0C with wdata_i = ID clears that in_service bit.
//   - An ID not in service, or out of range, is ignored.
//  Simultaneous events:
//   - New edge on a source in its claim cycle: pending stays set (the new event wins).
//   - we_i & re_i in the same cycle: the write takes effect; rdata_o shows the pre-write value.
//     A CLAIM read combined with a COMPLETE write does both.
//   - Writes to RO or unmapped offsets are ignored.
//  Level source still high after complete: re-pends and re-asserts e_intr_o 2 cycles later.
// CONFIGURATION
//  IRQ_SYNC_EN
//   - Defined: each src_i bit passes a 2-flop synchroniser (reset 0) before edge/level logic; latency +2 cycles.
//   - Undefined: src_i is assumed synchronous to clk_i and sampled directly.
// STRUCTURE
//  Package riscv_irq_ctrl_pkg:
//   - Register offset localparams (ENABLE_OFF, MODE_OFF, THRESH_OFF, CLAIM_OFF, PEND_OFF, PRIO_BASE).
//   - typedef irq_id_t (logic [$clog2(NUM_SRC+1)-1:0]).
//  Sub-module riscv_irq_arbiter:
//   - Combinational max-priority/lowest-ID select over eligible sources.
//   - Outputs: valid, best ID.
//  Top holds the registers, pending/in_service flops, the synchroniser and the bus decode.
// TESTING
//  1. Src 3 edge, PRIO=5, TH=0, en: pulse src_i[2] 1 cycle -> e_intr_o high 2 cycles later; CLAIM reads 3; e_intr_o low next cycle.
//  2. Src 2 PRIO=4, src 5 PRIO=6, both pending -> CLAIM reads 5, then 2 after completing 5; equal PRIO -> lower ID first.
//  3. THRESHOLD=6 with PRIO=6 pending -> e_intr_o stays 0; set THRESHOLD=5 -> e_intr_o high 1 cycle after write.
//  4. Level src 1 held high: claim -> no re-assert while in service; write 1 to 0x0C -> e_intr_o high again 2 cycles later.
//  5. Edge on src 4 in its own claim cycle -> PENDING[3]=1 after claim; COMPLETE with ID 7 (not in service) -> no state change.
//  6. rst_ni low mid-claim -> all outputs/registers 0 at once; with IRQ_SYNC_EN, scenario 1 latency = 4 cycles.

Source files
------------

// File: rtl/riscv_irq_ctrl_pkg.sv
// riscv_irq_ctrl_pkg: register map offsets and source ID type shared by the interrupt controller
package riscv_irq_ctrl_pkg;
  localparam int unsigned ENABLE_OFF = 32'h00;
  localparam int unsigned MODE_OFF   = 32'h04;
  localparam int unsigned THRESH_OFF = 32'h08;
  localparam int unsigned CLAIM_OFF  = 32'h0C;
  localparam int unsigned PEND_OFF   = 32'h10;
  localparam int unsigned PRIO_BASE  = 32'h20;
  // The ID type is sized for the largest legal NUM_SRC so one package serves every instance.
  localparam int unsigned MAX_SRC    = 31;
  typedef logic [$clog2(MAX_SRC+1)-1:0] irq_id_t;
endpackage

// File: rtl/riscv_irq_arbiter.sv
// riscv_irq_arbiter: picks the highest-priority eligible source, ties to lowest ID
//   elig_i  eligible source mask (bit i = ID i+1)
//   prio_i  per-source priority
//   valid_o any source eligible
//   id_o    best source ID (0 when none)
module riscv_irq_arbiter
  import riscv_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic [NUM_SRC-1:0]             elig_i,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
  output logic                           valid_o,
  output irq_id_t                        id_o
);
  logic [PRIO_W-1:0] best_p;
  // Ascending scan with strict compare keeps the lowest ID on equal priority.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    best_p  = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (elig_i[i] && (!valid_o || prio_i[i] > best_p)) begin
        valid_o = 1'b1;
        id_o    = irq_id_t'(i + 1);
        best_p  = prio_i[i];
      end
  end
endmodule

// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl: platform interrupt controller driving the core's machine external interrupt
//   clk_i/rst_ni  clock, asynchronous active-low reset
//   src_i         raw requests, bit i = source ID i+1
//   addr_i/we_i/wdata_i/re_i/rdata_o  word-addressed register port (CLAIM read has side effects)
//   e_intr_o      registered interrupt request
//   IRQ_SYNC_EN   when defined, src_i passes a 2-flop synchroniser before edge/level detection
module riscv_irq_ctrl
  import riscv_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ADDRW   = 12,
  parameter int DW      = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [ADDRW-1:0]   addr_i,
  input  logic               we_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic               re_i,
  output logic [DW-1:0]      rdata_o,
  output logic               e_intr_o
);
  logic [NUM_SRC-1:0]             en_q, mode_q, pend_q, ins_q, hist_q;
  logic [NUM_SRC-1:0]             pend_d, ins_d, s, elig, claim_oh, cmp_oh;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
  logic [PRIO_W-1:0]              th_q;
  logic [ADDRW-1:0]               a;
  logic                           irq_q, valid, claim, cmp;
  irq_id_t                        best;
`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  assign s = sync2_q;
`else
  assign s = src_i;
`endif
  assign a     = addr_i & ~ADDRW'(3);
  assign claim = re_i && a == ADDRW'(CLAIM_OFF);
  assign cmp   = we_i && a == ADDRW'(CLAIM_OFF);
  always_comb
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i]     = pend_q[i] & en_q[i] & ~ins_q[i] & (prio_q[i] > th_q);
      claim_oh[i] = claim && valid && best == irq_id_t'(i + 1);
      cmp_oh[i]   = cmp && wdata_i == DW'(i + 1);
    end
  riscv_irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_arb (
    .elig_i (elig),
    .prio_i (prio_q),
    .valid_o(valid),
    .id_o   (best)
  );
  // New events are ORed in after the claim clear so an edge in the claim cycle stays pending.
  assign pend_d = (pend_q & ~claim_oh) | (s & (~mode_q | ~hist_q));
  assign ins_d  = (ins_q & ~cmp_oh) | claim_oh;
  always_comb begin
    rdata_o = a == ADDRW'(ENABLE_OFF) ? DW'(en_q)   :
              a == ADDRW'(MODE_OFF)   ? DW'(mode_q) :
              a == ADDRW'(THRESH_OFF) ? DW'(th_q)   :
              a == ADDRW'(CLAIM_OFF)  ? DW'(best)   :
              a == ADDRW'(PEND_OFF)   ? DW'(pend_q) : '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (a == ADDRW'(PRIO_BASE + 4 * i)) rdata_o = DW'(prio_q[i]);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      en_q   <= '0;
      mode_q <= '0;
      th_q   <= '0;
      prio_q <= '0;
      pend_q <= '0;
      ins_q  <= '0;
      hist_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ins_q  <= ins_d;
      hist_q <= s;
      irq_q  <= valid;
      if (we_i) begin
        if (a == ADDRW'(ENABLE_OFF)) en_q <= wdata_i[NUM_SRC-1:0];
        if (a == ADDRW'(MODE_OFF)) mode_q <= wdata_i[NUM_SRC-1:0];
        if (a == ADDRW'(THRESH_OFF)) th_q <= wdata_i[PRIO_W-1:0];
        for (int i = 0; i < NUM_SRC; i++)
          if (a == ADDRW'(PRIO_BASE + 4 * i)) prio_q[i] <= wdata_i[PRIO_W-1:0];
      end
    end
  assign e_intr_o = irq_q;
endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// tb_riscv_irq_ctrl: directed self-checking bench for riscv_irq_ctrl
module tb_riscv_irq_ctrl;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  src_i = '0;
  logic [11:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic        e_intr_o;
  logic [31:0] sb[$];
  logic [31:0] v;
  int          total = 0;
  int          passed = 0;

  riscv_irq_ctrl dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .src_i   (src_i),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .wdata_i (wdata_i),
    .re_i    (re_i),
    .rdata_o (rdata_o),
    .e_intr_o(e_intr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = sb.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr_i = a;
    wdata_i = d;
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr_i = a;
    re_i = (a == 12'h00C);
    @(negedge clk_i);
    d = rdata_o;
    tick();
    re_i = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e);
    logic [31:0] d;
    push(e);
    rd(a, d);
    chk(tag, d);
  endtask

  task automatic irq_chk(input string tag, input logic e);
    push({31'b0, e});
    chk(tag, {31'b0, e_intr_o});
  endtask

  task automatic pulse(input int b);
    src_i[b] = 1'b1;
    tick();
    src_i[b] = 1'b0;
  endtask

  initial begin
    #12;
    irq_chk("rst_irq", 1'b0);
    push(32'h0); chk("rst_enable", rdata_o);
    addr_i = 12'h028;
    #1;
    push(32'h0); chk("rst_prio", rdata_o);
    tick();
    rst_ni = 1'b1;

    wr(12'h028, 5);
    wr(12'h000, 32'h04);
    wr(12'h004, 32'h04);
    pulse(2);
    repeat (SL) tick();
    irq_chk("t1_lat_lo", 1'b0);
    tick();
    irq_chk("t1_lat_hi", 1'b1);
    rd_chk("t1_claim", 12'h00C, 3);
    irq_chk("t1_hold", 1'b1);
    tick();
    irq_chk("t1_drop", 1'b0);
    rd_chk("t1_pend", 12'h010, 0);
    wr(12'h00C, 3);

    wr(12'h024, 4);
    wr(12'h030, 6);
    wr(12'h000, 32'h16);
    wr(12'h004, 32'h16);
    src_i[1] = 1'b1; src_i[4] = 1'b1;
    tick();
    src_i = '0;
    repeat (SL + 1) tick();
    rd_chk("t2_claim_hi", 12'h00C, 5);
    wr(12'h00C, 5);
    rd_chk("t2_claim_lo", 12'h00C, 2);
    wr(12'h00C, 2);
    wr(12'h030, 4);
    src_i[1] = 1'b1; src_i[4] = 1'b1;
    tick();
    src_i = '0;
    repeat (SL + 1) tick();
    rd_chk("t2_tie_first", 12'h00C, 2);
    wr(12'h00C, 2);
    rd_chk("t2_tie_second", 12'h00C, 5);
    wr(12'h00C, 5);
    rd_chk("t2_none", 12'h00C, 0);

    wr(12'h008, 6);
    wr(12'h030, 6);
    pulse(4);
    repeat (SL + 2) tick();
    irq_chk("t3_masked", 1'b0);
    rd_chk("t3_pend", 12'h010, 32'h10);
    wr(12'h008, 5);
    irq_chk("t3_wr_edge", 1'b0);
    tick();
    irq_chk("t3_th_lowered", 1'b1);
    rd_chk("t3_claim", 12'h00C, 5);
    wr(12'h00C, 5);
    wr(12'h008, 0);

    wr(12'h020, 2);
    wr(12'h000, 32'h17);
    src_i[0] = 1'b1;
    repeat (SL + 2) tick();
    irq_chk("t4_irq", 1'b1);
    rd_chk("t4_claim", 12'h00C, 1);
    tick();
    irq_chk("t4_insvc_a", 1'b0);
    tick();
    irq_chk("t4_insvc_b", 1'b0);
    rd_chk("t4_repend", 12'h010, 32'h01);
    wr(12'h00C, 1);
    irq_chk("t4_cmp_lo", 1'b0);
    tick();
    irq_chk("t4_cmp_hi", 1'b1);
    src_i[0] = 1'b0;
    repeat (SL + 1) tick();
    rd_chk("t4_claim2", 12'h00C, 1);
    wr(12'h00C, 1);
    rd_chk("t4_clear", 12'h010, 0);

    wr(12'h02C, 3);
    wr(12'h000, 32'h1F);
    wr(12'h004, 32'h1E);
    pulse(3);
    repeat (SL + 1) tick();
    irq_chk("t5_irq", 1'b1);
    src_i[3] = 1'b1;
    repeat (SL) tick();
    rd_chk("t5_claim", 12'h00C, 4);
    src_i[3] = 1'b0;
    rd_chk("t5_pend_kept", 12'h010, 32'h08);
    tick();
    irq_chk("t5_insvc", 1'b0);
    wr(12'h00C, 7);
    rd_chk("t5_badid_pend", 12'h010, 32'h08);
    rd_chk("t5_badid_en", 12'h000, 32'h1F);
    tick();
    irq_chk("t5_badid_irq", 1'b0);
    wr(12'h00C, 4);
    tick();
    irq_chk("t5_recmp", 1'b1);
    rd_chk("t5_claim2", 12'h00C, 4);
    wr(12'h00C, 4);

    wr(12'h010, 32'hFF);
    rd_chk("ro_pend", 12'h010, 0);
    wr(12'h014, 32'hFF);
    rd_chk("unmapped", 12'h014, 0);
    rd_chk("prio_rd", 12'h02C, 3);
    rd_chk("prio_oob", 12'h040, 0);
    rd_chk("mode_rd", 12'h004, 32'h1E);

    pulse(2);
    repeat (SL + 1) tick();
    irq_chk("t6_pre", 1'b1);
    addr_i = 12'h00C;
    re_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    irq_chk("t6_irq", 1'b0);
    push(0); chk("t6_claim", rdata_o);
    addr_i = 12'h000;
    #1;
    push(0); chk("t6_enable", rdata_o);
    re_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    rd_chk("t6_prio", 12'h028, 0);
    rd_chk("t6_pend", 12'h010, 0);
    pulse(2);
    repeat (SL + 2) tick();
    irq_chk("t6_disabled", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
